// File: rtl/t1_sim_watchdog.sv
// Multi-channel simulation watchdog: per-channel inactivity timeout, global cycle limit,
// end-of-test drain check and wave-dump window, reporting a sticky pass/fail status code.
module t1_sim_watchdog #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 64,
  parameter int TIMEOUT_W    = 32,
  parameter int DRAIN_CYCLES = 16,
  localparam int FCH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  input  logic [CNT_W-1:0]     cfg_global_timeout,
  input  logic [CNT_W-1:0]     cfg_dump_start,
  input  logic [CNT_W-1:0]     cfg_dump_end,
  input  logic [NUM_CH-1:0]    ch_enable,
  input  logic [NUM_CH-1:0]    ch_retire,
  input  logic [NUM_CH-1:0]    ch_done,
  output logic [CNT_W-1:0]     cycle,
  output logic [7:0]           status,
  output logic [FCH_W-1:0]     fail_ch,
  output logic                 dump_en,
  output logic                 finish
);

  localparam int DC_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_PASS, S_FAIL} state_t;

  state_t               state;
  logic [TIMEOUT_W-1:0] timeout_reg;
  logic [CNT_W-1:0]     global_reg;
  logic [CNT_W-1:0]     dstart_reg;
  logic [CNT_W-1:0]     dend_reg;
  logic [DC_W-1:0]      drain_cnt;

  logic [CNT_W-1:0]  cycle_inc;
  logic              glob_hit;
  logic              all_done;
  logic              drain_done;
  logic              terminal;
  logic              dump_next;
  logic [NUM_CH-1:0] to_vec;
  logic [NUM_CH-1:0] dr_vec;
  logic [FCH_W-1:0]  to_idx;
  logic [FCH_W-1:0]  dr_idx;

  function automatic logic in_window(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] s,
                                     input logic [CNT_W-1:0] e);
    return (c >= s) && ((e == '0) || (c < e));
  endfunction

  // Idle counters run only while a channel is enabled, not done and the FSM is in RUN.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [TIMEOUT_W-1:0] idle_cnt;
      logic                 active;

      assign active      = ch_enable[gi] & ~ch_done[gi];
      assign to_vec[gi]  = (state == S_RUN) && active && !ch_retire[gi] && (timeout_reg != '0) &&
                           (idle_cnt != '1) && (idle_cnt + TIMEOUT_W'(1) == timeout_reg);
      assign dr_vec[gi]  = ch_enable[gi] & ch_retire[gi];

      always_ff @(posedge clock or negedge reset) begin
        if (!reset)
          idle_cnt <= '0;
        else if (state != S_RUN || !active || ch_retire[gi])
          idle_cnt <= '0;
        else if (idle_cnt != '1)
          idle_cnt <= idle_cnt + TIMEOUT_W'(1);
      end
    end
  endgenerate

  always_comb begin
    cycle_inc  = (cycle == '1) ? cycle : cycle + CNT_W'(1);
    glob_hit   = (state == S_RUN || state == S_DRAIN) && (global_reg != '0) &&
                 (cycle != '1) && (cycle + CNT_W'(1) == global_reg);
    all_done   = &(ch_done | ~ch_enable);
    drain_done = all_done && (drain_cnt == DRAIN_LAST);
    to_idx     = '0;
    dr_idx     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (to_vec[i]) to_idx = FCH_W'(i);
      if (dr_vec[i]) dr_idx = FCH_W'(i);
    end
    terminal  = glob_hit || (state == S_RUN && |to_vec) ||
                (state == S_DRAIN && (|dr_vec || drain_done));
    // dump_en is aligned with the cycle value it will be shown next to.
    dump_next = 1'b0;
    if (state == S_IDLE && start)
      dump_next = in_window('0, cfg_dump_start, cfg_dump_end);
    else if ((state == S_RUN || state == S_DRAIN) && !terminal)
      dump_next = in_window(cycle_inc, dstart_reg, dend_reg);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cycle       <= '0;
      status      <= '0;
      fail_ch     <= '0;
      dump_en     <= 1'b0;
      finish      <= 1'b0;
      drain_cnt   <= '0;
      timeout_reg <= '0;
      global_reg  <= '0;
      dstart_reg  <= '0;
      dend_reg    <= '0;
    end else begin
      finish  <= 1'b0;
      dump_en <= dump_next;
      if (glob_hit) begin
        state  <= S_FAIL;
        status <= 8'd2;
        cycle  <= cycle_inc;
        finish <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            timeout_reg <= cfg_timeout;
            global_reg  <= cfg_global_timeout;
            dstart_reg  <= cfg_dump_start;
            dend_reg    <= cfg_dump_end;
            cycle       <= '0;
            drain_cnt   <= '0;
            state       <= S_RUN;
          end
          S_RUN: if (|to_vec) begin
            state   <= S_FAIL;
            status  <= 8'd1;
            fail_ch <= to_idx;
            finish  <= 1'b1;
          end else begin
            cycle <= cycle_inc;
            if (all_done) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end
          end
          S_DRAIN: if (|dr_vec) begin
            state   <= S_FAIL;
            status  <= 8'd3;
            fail_ch <= dr_idx;
            finish  <= 1'b1;
          end else if (!all_done) begin
            state <= S_RUN;
            cycle <= cycle_inc;
          end else if (drain_cnt == DRAIN_LAST) begin
            state  <= S_PASS;
            status <= 8'hFF;
            finish <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DC_W'(1);
            cycle     <= cycle_inc;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_t1_sim_watchdog.sv
// Directed and randomized bench for t1_sim_watchdog against a timestamp-based reference model.
module tb_t1_sim_watchdog;
  localparam int DRAIN = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cfg_timeout = '0;
  logic [63:0] cfg_global_timeout = '0;
  logic [63:0] cfg_dump_start = '0;
  logic [63:0] cfg_dump_end = '0;
  logic [3:0]  ch_enable = '0;
  logic [3:0]  ch_retire = '0;
  logic [3:0]  ch_done = '0;
  logic [63:0] cycle;
  logic [7:0]  status;
  logic [1:0]  fail_ch;
  logic        dump_en;
  logic        finish;

  t1_sim_watchdog dut (
    .clock(clock), .reset(reset), .start(start),
    .cfg_timeout(cfg_timeout), .cfg_global_timeout(cfg_global_timeout),
    .cfg_dump_start(cfg_dump_start), .cfg_dump_end(cfg_dump_end),
    .ch_enable(ch_enable), .ch_retire(ch_retire), .ch_done(ch_done),
    .cycle(cycle), .status(status), .fail_ch(fail_ch), .dump_en(dump_en), .finish(finish)
  );

  always #5 clock = ~clock;

  // Reference model: phase 0 idle, 1 run, 2 drain, 3 pass, 4 fail; time measured in edges since start.
  int          m_phase;
  logic [63:0] m_cycle;
  int          m_status, m_fail;
  bit          m_dump, m_finish;
  logic [31:0] m_to;
  logic [63:0] m_g, m_ds, m_de;
  int          e_now, drain_at;
  int          last_act [4];

  int n_cmp = 0, n_err = 0;
  int edges, fin_edge;
  bit fin_seen;
  bit [3:0] ret_always, ret_never;
  int ret_pct;

  task automatic model_reset();
    m_phase = 0; m_cycle = '0; m_status = 0; m_fail = 0; m_dump = 0; m_finish = 0;
    m_to = '0; m_g = '0; m_ds = '0; m_de = '0; e_now = 0; drain_at = 0;
    for (int i = 0; i < 4; i++) last_act[i] = 0;
  endtask

  task automatic model_edge();
    logic [63:0] c1;
    int code, fch;
    bit alldone, act;
    m_finish = 0;
    if (!reset) begin
      model_reset();
      return;
    end
    if (m_phase == 0 && start) begin
      m_to = cfg_timeout; m_g = cfg_global_timeout; m_ds = cfg_dump_start; m_de = cfg_dump_end;
      m_phase = 1; m_cycle = '0; e_now = 0;
      for (int i = 0; i < 4; i++) last_act[i] = 0;
    end else if (m_phase == 1 || m_phase == 2) begin
      e_now++;
      c1 = m_cycle + 64'd1;
      alldone = ((ch_done | ~ch_enable) == 4'hF);
      code = 0; fch = 0;
      if (m_g != 0 && c1 == m_g) code = 2;
      else if (m_phase == 1) begin
        for (int i = 3; i >= 0; i--) begin
          act = ch_enable[i] && !ch_done[i] && !ch_retire[i];
          if (act && m_to != 0 && (e_now - last_act[i]) == int'(m_to)) begin code = 1; fch = i; end
        end
      end else begin
        for (int i = 3; i >= 0; i--)
          if (ch_enable[i] && ch_retire[i]) begin code = 3; fch = i; end
      end
      for (int i = 0; i < 4; i++)
        if (m_phase == 2 || !ch_enable[i] || ch_done[i] || ch_retire[i]) last_act[i] = e_now;
      if (code != 0) begin
        m_phase = 4; m_status = code; m_finish = 1;
        if (code == 2) m_cycle = c1; else m_fail = fch;
      end else if (m_phase == 1) begin
        m_cycle = c1;
        if (alldone) begin m_phase = 2; drain_at = e_now; end
      end else if (!alldone) begin
        m_phase = 1; m_cycle = c1;
      end else if (e_now - drain_at == DRAIN) begin
        m_phase = 3; m_status = 255; m_finish = 1;
      end else m_cycle = c1;
    end
    m_dump = (m_phase == 1 || m_phase == 2) && (m_cycle >= m_ds) && (m_de == 0 || m_cycle < m_de);
  endtask

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_all();
    chk("status", 64'(status), 64'(m_status));
    chk("fail_ch", 64'(fail_ch), 64'(m_fail));
    chk("cycle", cycle, m_cycle);
    chk("dump_en", 64'(dump_en), 64'(m_dump));
    chk("finish", 64'(finish), 64'(m_finish));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    edges++;
    if (finish === 1'b1) begin fin_seen = 1; fin_edge = edges; end
    check_all();
    $display("t=%0t cyc=%0d status=%0d fail_ch=%0d dump=%0b finish=%0b", $time, cycle, status,
             fail_ch, dump_en, finish);
  endtask

  task automatic drive_retire();
    for (int i = 0; i < 4; i++)
      ch_retire[i] = ret_never[i] ? 1'b0 : ret_always[i] ? 1'b1 : ($urandom_range(0, 99) < ret_pct);
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; ch_retire = '0; ch_done = '0;
    step();
    reset = 1'b1;
  endtask

  task automatic begin_run(input logic [31:0] to, input logic [63:0] g, input logic [63:0] ds,
                           input logic [63:0] de, input logic [3:0] en);
    cfg_timeout = to; cfg_global_timeout = g; cfg_dump_start = ds; cfg_dump_end = de;
    ch_enable = en; ch_done = '0; ch_retire = '0; start = 1'b1;
    edges = -1; fin_seen = 0; fin_edge = -1;
    step();
    start = 1'b0;
    // Scramble the config inputs so later behaviour relies on the latched copy.
    cfg_timeout = $urandom; cfg_global_timeout = {$urandom, $urandom};
    cfg_dump_start = {$urandom, $urandom}; cfg_dump_end = {$urandom, $urandom};
  endtask

  task automatic run_to_finish(input int budget);
    for (int k = 0; k < budget && !fin_seen; k++) begin
      drive_retire();
      step();
    end
    ch_retire = '0;
    chk("finish_within_budget", 64'(fin_seen), 64'd1);
  endtask

  task automatic run_to_cycle(input int target);
    for (int k = 0; k < 200 && m_cycle != 64'(target); k++) begin
      drive_retire();
      step();
    end
  endtask

  initial begin
    int dcnt, dfirst, dlast, done_at;
    model_reset();
    ret_always = '0; ret_never = '0; ret_pct = 0;
    step();
    chk("reset_status", 64'(status), 64'd0);
    chk("reset_cycle", cycle, 64'd0);
    reset = 1'b1;

    // Channel 1 silent with timeout 5.
    ret_always = 4'b1101; ret_never = 4'b0010;
    begin_run(5, 0, 0, 0, 4'hF);
    run_to_finish(40);
    chk("ch_to_status", 64'(status), 64'd1);
    chk("ch_to_fail_ch", 64'(fail_ch), 64'd1);
    chk("ch_to_latency", 64'(fin_edge), 64'd5);

    // Global timeout at 100; cycle must stay frozen afterwards.
    do_reset();
    ret_always = 4'hF; ret_never = '0;
    begin_run(0, 100, 0, 0, 4'hF);
    run_to_finish(150);
    chk("glob_status", 64'(status), 64'd2);
    chk("glob_cycle", cycle, 64'd100);
    repeat (3) step();
    chk("glob_frozen", cycle, 64'd100);

    // All done at cycle 20, then quiet drain.
    do_reset();
    ret_always = 4'hF;
    begin_run(0, 0, 0, 0, 4'hF);
    run_to_cycle(20);
    ch_done = 4'hF; ret_always = '0; ret_pct = 0;
    run_to_finish(40);
    chk("pass_status", 64'(status), 64'd255);
    chk("pass_cycle", cycle, 64'd36);

    // Channels 0 and 2 time out together; then again with a coincident global timeout.
    do_reset();
    ret_always = 4'b1010; ret_never = 4'b0101;
    begin_run(8, 0, 0, 0, 4'hF);
    run_to_finish(30);
    chk("multi_to_status", 64'(status), 64'd1);
    chk("multi_to_fail_ch", 64'(fail_ch), 64'd0);
    do_reset();
    begin_run(8, 8, 0, 0, 4'hF);
    run_to_finish(30);
    chk("glob_prio_status", 64'(status), 64'd2);
    chk("glob_prio_cycle", cycle, 64'd8);

    // Retire on channel 3 at drain count 4.
    do_reset();
    ret_always = 4'hF; ret_never = '0;
    begin_run(0, 0, 0, 0, 4'hF);
    run_to_cycle(10);
    ch_done = 4'hF; ch_retire = '0;
    repeat (5) step();
    ch_retire = 4'b1000;
    step();
    ch_retire = '0;
    chk("drain_ret_status", 64'(status), 64'd3);
    chk("drain_ret_fail_ch", 64'(fail_ch), 64'd3);

    // No channels enabled: drains straight away; start in PASS is ignored.
    do_reset();
    ret_always = '0; ret_pct = 50;
    begin_run(0, 0, 0, 0, 4'h0);
    run_to_finish(40);
    chk("empty_status", 64'(status), 64'd255);
    chk("empty_cycle", cycle, 64'd16);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("sticky_status", 64'(status), 64'd255);

    // Dump window 10..19, async reset at cycle 15, then restart.
    do_reset();
    ret_always = 4'hF; ret_pct = 0;
    begin_run(0, 0, 10, 20, 4'hF);
    run_to_cycle(15);
    chk("dump_mid", 64'(dump_en), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_cycle", cycle, 64'd0);
    chk("async_dump", 64'(dump_en), 64'd0);
    chk("async_finish", 64'(finish), 64'd0);
    model_reset();
    step();
    reset = 1'b1;
    begin_run(0, 0, 10, 20, 4'hF);
    dcnt = 0; dfirst = -1; dlast = -1;
    for (int k = 0; k < 25; k++) begin
      drive_retire();
      step();
      if (dump_en === 1'b1) begin
        dcnt++; dlast = int'(cycle);
        if (dfirst < 0) dfirst = int'(cycle);
      end
    end
    chk("dump_count", 64'(dcnt), 64'd10);
    chk("dump_first", 64'(dfirst), 64'd10);
    chk("dump_last", 64'(dlast), 64'd19);

    // Randomized runs.
    for (int r = 0; r < 25; r++) begin
      do_reset();
      ret_always = '0; ret_never = '0; ret_pct = $urandom_range(30, 95);
      done_at = $urandom_range(5, 60);
      begin_run(($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(3, 15)),
                ($urandom_range(0, 1) == 0) ? 64'd0 : 64'($urandom_range(30, 150)),
                64'($urandom_range(0, 40)),
                ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(0, 60)),
                4'($urandom_range(0, 15)));
      for (int k = 0; k < 250 && !fin_seen; k++) begin
        drive_retire();
        if (m_cycle >= 64'(done_at)) begin
          ch_done = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'hF;
          ch_retire = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'h0;
        end
        step();
      end
      ch_retire = '0; ch_done = '0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
